logic_op_sequencer: RTL and testbench

//  Front end that drives the 4-bit AND/OR/XOR and 8-bit NOT logic units.
//  - Debounces a board push-button.
//  - Snapshots operands x,y from the switches.
//  - Steps through the four logic operations, one per press.
//  - Presents each registered result to the display stage via a valid/ready handshake.
//

---
 rtl/logic_op_sequencer.sv | 131 +++++++++++++
 tb/tb_logic_op_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_sequencer.sv
// Push-button driven sequencer for the AND/OR/XOR/NOT logic units.
// It debounces the key, captures the operands and hands each result to the display over valid/ready.
module logic_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_x,
    input  logic [3:0] sw_y,
    input  logic       key_n,
    input  logic       res_ready,
    output logic [7:0] result,
    output logic       res_valid,
    output logic [1:0] op_code,
    output logic [3:0] en_op,
    output logic       ovr
);

    // state | meaning
    // IDLE  | waiting for first press, result cleared
    // S_AND | result = x & y
    // S_OR  | result = x | y
    // S_XOR | result = x ^ y
    // S_NOT | result = ~{y,x}

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, S_AND, S_OR, S_XOR, S_NOT} state_t;

    state_t             state, state_nx;
    logic               key_m, key_s, key_db;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_tc, press, accept;
    logic [3:0]         xr, yr, opx, opy;
    logic [7:0]         result_nx;
    logic [1:0]         op_nx;
    logic               valid_nx, ovr_nx;

    // Synchronizer and debouncer both reset to the released level so reset never creates a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m  <= 1'b1;
            key_s  <= 1'b1;
            key_db <= 1'b1;
            cnt    <= '0;
        end else begin
            key_m <= key_n;
            key_s <= key_m;
            if (key_s == key_db) begin
                cnt <= '0;
            end else if (cnt_tc) begin
                key_db <= key_s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign cnt_tc = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press  = cnt_tc && (key_s != key_db) && !key_s;
    assign accept = press && (!res_valid || res_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            xr        <= '0;
            yr        <= '0;
            result    <= '0;
            op_code   <= '0;
            res_valid <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            state     <= state_nx;
            result    <= result_nx;
            op_code   <= op_nx;
            res_valid <= valid_nx;
            ovr       <= ovr_nx;
            if (accept && state == IDLE) begin
                xr <= sw_x;
                yr <= sw_y;
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            case (state)
                IDLE:    state_nx = S_AND;
                S_AND:   state_nx = S_OR;
                S_OR:    state_nx = S_XOR;
                S_XOR:   state_nx = S_NOT;
                S_NOT:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Leaving IDLE the operand registers are loaded on this same edge, so use the switches directly.
    assign opx = (state == IDLE) ? sw_x : xr;
    assign opy = (state == IDLE) ? sw_y : yr;

    always_comb begin
        result_nx = result;
        op_nx     = op_code;
        valid_nx  = res_valid;
        ovr_nx    = ovr | (press && res_valid && !res_ready);
        en_op     = 4'b0000;
        if (accept) begin
            valid_nx = (state_nx != IDLE);
            case (state_nx)
                S_AND:   begin result_nx = {4'h0, opx & opy}; op_nx = 2'd0; end
                S_OR:    begin result_nx = {4'h0, opx | opy}; op_nx = 2'd1; end
                S_XOR:   begin result_nx = {4'h0, opx ^ opy}; op_nx = 2'd2; end
                S_NOT:   begin result_nx = ~{opy, opx};       op_nx = 2'd3; end
                default: begin result_nx = 8'h00;             op_nx = 2'd0; end
            endcase
        end else if (res_valid && res_ready) begin
            valid_nx = 1'b0;
        end
        case (state)
            S_AND:   en_op = 4'b0001;
            S_OR:    en_op = 4'b0010;
            S_XOR:   en_op = 4'b0100;
            S_NOT:   en_op = 4'b1000;
            default: en_op = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Self-checking bench for logic_op_sequencer: operand table plus hand-written handshake,
// debounce and reset sequences; every handshake transfer is scored against a queue.
module tb_logic_op_sequencer;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_x, sw_y;
    logic       key_n, res_ready;
    logic [7:0] result;
    logic       res_valid;
    logic [1:0] op_code;
    logic [3:0] en_op;
    logic       ovr;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic [7:0] res;
        logic [1:0] op;
        logic [3:0] en;
    } sb_t;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] exp_res [4];
    } vec_t;

    sb_t  sbq[$];
    sb_t  mon_e;
    vec_t tab[4];

    logic_op_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw_x(sw_x), .sw_y(sw_y), .key_n(key_n),
        .res_ready(res_ready), .result(result), .res_valid(res_valid),
        .op_code(op_code), .en_op(en_op), .ovr(ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] r, input int i);
        sb_t e;
        e.res = r;
        e.op  = 2'(i);
        e.en  = 4'(1 << i);
        sbq.push_back(e);
    endtask

    task automatic press();
        @(negedge clk) key_n = 1'b0;
        repeat (DB + 2) @(posedge clk);
        @(negedge clk) key_n = 1'b1;
        repeat (DB + 3) @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [3:0] x, input logic [3:0] y,
                           input logic [7:0] a, input logic [7:0] o,
                           input logic [7:0] xo, input logic [7:0] n);
        tab[i].x = x;
        tab[i].y = y;
        tab[i].exp_res[0] = a;
        tab[i].exp_res[1] = o;
        tab[i].exp_res[2] = xo;
        tab[i].exp_res[3] = n;
    endtask

    // Scoreboard: a transfer happens on any edge that sees res_valid && res_ready.
    always @(posedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", {24'h0, result}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sbq.pop_front();
                chk("xfer_result", {24'h0, result}, {24'h0, mon_e.res});
                chk("xfer_op_code", {30'h0, op_code}, {30'h0, mon_e.op});
                chk("xfer_en_op", {28'h0, en_op}, {28'h0, mon_e.en});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        set_vec(0, 4'hC, 4'hA, 8'h08, 8'h0E, 8'h06, 8'h53);
        set_vec(1, 4'hF, 4'h0, 8'h00, 8'h0F, 8'h0F, 8'hF0);
        set_vec(2, 4'h5, 4'h3, 8'h01, 8'h07, 8'h06, 8'hCA);
        set_vec(3, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'hFF);

        rst_n = 1'b0; key_n = 1'b1; res_ready = 1'b0; sw_x = '0; sw_y = '0;
        #1;
        chk("rst_result", {24'h0, result}, 32'h0);
        chk("rst_valid", {31'h0, res_valid}, 32'h0);
        chk("rst_en_op", {28'h0, en_op}, 32'h0);
        chk("rst_ovr", {31'h0, ovr}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (DB + 4) @(posedge clk);
        #1 chk("idle_no_spurious", {28'h0, en_op}, 32'h0);

        // Table: full AND/OR/XOR/NOT/IDLE cycle per operand pair, display always ready.
        for (int v = 0; v < 4; v++) begin
            sw_x = tab[v].x; sw_y = tab[v].y; res_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                push(tab[v].exp_res[i], i);
                press();
            end
            press();
            chk("idle_result", {24'h0, result}, 32'h0);
            chk("idle_valid", {31'h0, res_valid}, 32'h0);
            chk("idle_en_op", {28'h0, en_op}, 32'h0);
            chk("idle_op_code", {30'h0, op_code}, 32'h0);
            chk("tab_ovr", {31'h0, ovr}, 32'h0);
        end

        // Debounce latency and glitch rejection.
        sw_x = 4'h5; sw_y = 4'h3; res_ready = 1'b1;
        push(8'h01, 0);
        @(negedge clk) key_n = 1'b0;
        repeat (DB + 1) @(posedge clk);
        #1 chk("lat_early", {28'h0, en_op}, 32'h0);
        @(posedge clk);
        #1 chk("lat_edge", {28'h0, en_op}, 32'h1);
        @(negedge clk) key_n = 1'b1;
        repeat (DB + 3) @(posedge clk);
        @(negedge clk) key_n = 1'b0;
        repeat (DB - 1) @(posedge clk);
        @(negedge clk) key_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("glitch_en_op", {28'h0, en_op}, 32'h1);
        chk("glitch_op_code", {30'h0, op_code}, 32'h0);
        push(8'h07, 1); press();
        push(8'h06, 2); press();
        push(8'hCA, 3); press();
        press();

        // Handshake and press on the same edge; switches changed after capture.
        sw_x = 4'hC; sw_y = 4'hA; res_ready = 1'b0;
        push(8'h08, 0);
        press();
        chk("hold_valid", {31'h0, res_valid}, 32'h1);
        chk("hold_result", {24'h0, result}, 32'h08);
        sw_x = 4'hF;
        push(8'h0E, 1);
        @(negedge clk) key_n = 1'b0;
        repeat (DB + 1) @(posedge clk);
        @(negedge clk) res_ready = 1'b1;
        @(posedge clk);
        #1 chk("same_edge_result", {24'h0, result}, 32'h0E);
        chk("same_edge_valid", {31'h0, res_valid}, 32'h1);
        chk("same_edge_ovr", {31'h0, ovr}, 32'h0);
        chk("same_edge_op_code", {30'h0, op_code}, 32'h1);
        @(negedge clk) key_n = 1'b1;
        repeat (DB + 3) @(posedge clk);
        #1 chk("same_edge_drained", {31'h0, res_valid}, 32'h0);
        push(8'h06, 2); press();
        push(8'h53, 3); press();
        press();

        // Dropped press while result pending.
        sw_x = 4'hC; sw_y = 4'hA; res_ready = 1'b0;
        push(8'h08, 0);
        press();
        press();
        chk("drop_en_op", {28'h0, en_op}, 32'h1);
        chk("drop_result", {24'h0, result}, 32'h08);
        chk("drop_ovr", {31'h0, ovr}, 32'h1);
        chk("drop_valid", {31'h0, res_valid}, 32'h1);
        @(negedge clk) res_ready = 1'b1;
        @(posedge clk);
        #1 chk("drop_release_valid", {31'h0, res_valid}, 32'h0);
        chk("ovr_sticky", {31'h0, ovr}, 32'h1);

        // Asynchronous reset while in S_XOR with a pending result.
        push(8'h0E, 1); press();
        @(negedge clk) res_ready = 1'b0;
        press();
        chk("pre_rst_result", {24'h0, result}, 32'h06);
        chk("pre_rst_valid", {31'h0, res_valid}, 32'h1);
        @(negedge clk) #2 rst_n = 1'b0;
        #1;
        chk("arst_result", {24'h0, result}, 32'h0);
        chk("arst_valid", {31'h0, res_valid}, 32'h0);
        chk("arst_op_code", {30'h0, op_code}, 32'h0);
        chk("arst_en_op", {28'h0, en_op}, 32'h0);
        chk("arst_ovr", {31'h0, ovr}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        res_ready = 1'b1; sw_x = 4'h5; sw_y = 4'h3;
        push(8'h01, 0);
        press();
        chk("post_rst_en_op", {28'h0, en_op}, 32'h1);
        chk("sb_empty", sbq.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
